// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the 32-bit machine word and the
// request-sequencer state encoding used by pc_request_unit.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } reqstate_t;

   localparam word_t PC_STEP = 32'd4;

   // Instruction addresses are always word aligned; low two bits are dropped.
   function automatic word_t align_word(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/req_perf_counters.sv
// Retired-instruction and stall-cycle counters for pc_request_unit.
// Built only when REQ_PERF_EN is defined. Both counters wrap at 2^32,
// freeze while the core is halted and clear on the synchronous reset.
module req_perf_counters
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  pc_en,
   input  logic  stall,
   input  logic  halt,
   output word_t instr_count,
   output word_t stall_cycles
);

   word_t r_instr_count;
   word_t r_stall_cycles;

   // Count retirements and stalled cycles; hold both while halted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_instr_count  <= '0;
         r_stall_cycles <= '0;
      end else if (!halt) begin
         if (pc_en) r_instr_count  <= r_instr_count + 32'd1;
         if (stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign instr_count  = r_instr_count;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: rtl/pc_request_unit.sv
// Program counter owner and single-memory-port sequencer.
// FETCH issues an instruction read; a load/store parks the PC in DATA
// until dhit; halt_in parks everything in HALTED until reset.
// Optional feature macro: REQ_PERF_EN (performance counters).
module pc_request_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
)
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  ihit,
   input  logic  dhit,
   input  logic  MemRead,
   input  logic  MemWrite,
   input  logic  PCSrc,
   input  logic  Jump,
   input  logic  halt_in,
   input  word_t branch_target,
   input  word_t jump_target,
   output word_t pc,
   output word_t pc_plus4,
   output logic  imemREN,
   output logic  dmemREN,
   output logic  dmemWEN,
   output logic  pc_en,
   output logic  halt,
   output word_t instr_count,
   output word_t stall_cycles
);

   reqstate_t r_state;
   word_t     r_pc;
   word_t     r_npc_q;
   logic      r_imem_ren;
   logic      r_rd_q;
   logic      r_wr_q;
   logic      r_halt;

   word_t     w_pc_plus4;
   word_t     w_next_pc;
   logic      w_mem_op;
   logic      w_pc_en;

   assign w_pc_plus4 = r_pc + PC_STEP;
   assign w_mem_op   = MemRead | MemWrite;
   // Jump wins over a taken branch; fall-through is pc+4 (wraps naturally).
   assign w_next_pc  = align_word(Jump ? jump_target : (PCSrc ? branch_target : w_pc_plus4));

   // Retire strobe: same-cycle pulse when the PC will load at this edge.
   always_comb begin
      // NOTE: default first so every path assigns w_pc_en and no latch is inferred.
      w_pc_en = 1'b0;
      if (!RST) begin
         case (r_state)
            FETCH:   w_pc_en = ihit & ~halt_in & ~w_mem_op;
            DATA:    w_pc_en = dhit;
            default: w_pc_en = 1'b0;
         endcase
      end
   end

   // Sequencer FSM, PC register and registered Moore request outputs.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         r_state    <= FETCH;
         r_pc       <= PC_INIT;
         r_npc_q    <= '0;
         r_imem_ren <= 1'b1;
         r_rd_q     <= 1'b0;
         r_wr_q     <= 1'b0;
         r_halt     <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (ihit) begin
                  if (halt_in) begin
                     r_state    <= HALTED;
                     r_imem_ren <= 1'b0;
                     r_halt     <= 1'b1;
                  end else if (w_mem_op) begin
                     // A store takes priority when both load and store are flagged.
                     r_state    <= DATA;
                     r_npc_q    <= w_next_pc;
                     r_imem_ren <= 1'b0;
                     r_rd_q     <= MemRead & ~MemWrite;
                     r_wr_q     <= MemWrite;
                  end else begin
                     r_pc <= w_next_pc;
                  end
               end
            end
            DATA: begin
               if (dhit) begin
                  r_state    <= FETCH;
                  r_pc       <= r_npc_q;
                  r_imem_ren <= 1'b1;
                  r_rd_q     <= 1'b0;
                  r_wr_q     <= 1'b0;
               end
            end
            default: begin
               r_state    <= HALTED;
               r_imem_ren <= 1'b0;
               r_rd_q     <= 1'b0;
               r_wr_q     <= 1'b0;
               r_halt     <= 1'b1;
            end
         endcase
      end
   end

   assign pc       = r_pc;
   assign pc_plus4 = w_pc_plus4;
   assign imemREN  = r_imem_ren;
   assign dmemREN  = r_rd_q;
   assign dmemWEN  = r_wr_q;
   assign pc_en    = w_pc_en;
   assign halt     = r_halt;

`ifdef REQ_PERF_EN
   logic w_stall;

   // Waiting on instruction memory in FETCH, or on data memory in DATA.
   assign w_stall = ~RST & (((r_state == FETCH) & ~ihit) | ((r_state == DATA) & ~dhit));

   req_perf_counters u_perf (
      .CLK          (CLK),
      .RST          (RST),
      .pc_en        (w_pc_en),
      .stall        (w_stall),
      .halt         (r_state == HALTED),
      .instr_count  (instr_count),
      .stall_cycles (stall_cycles)
   );
`else
   assign instr_count  = '0;
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pc_request_unit.sv
// Self-checking bench for pc_request_unit: directed scenarios followed by
// random stimulus, all compared against a behavioural instruction-level model.
module tb_pc_request_unit;
   import cpu_types_pkg::*;

   localparam word_t PC_INIT = 32'h0000_0100;

   logic  CLK = 1'b0;
   logic  RST, ihit, dhit, MemRead, MemWrite, PCSrc, Jump, halt_in;
   word_t branch_target, jump_target;
   word_t pc, pc_plus4, instr_count, stall_cycles;
   logic  imemREN, dmemREN, dmemWEN, pc_en, halt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: architectural PC, a pending data access, sticky halt, counters.
   word_t m_pc     = PC_INIT;
   bit    m_busy   = 1'b0;
   bit    m_wr     = 1'b0;
   word_t m_target = '0;
   bit    m_halted = 1'b0;
   word_t m_icnt   = '0;
   word_t m_scnt   = '0;

   pc_request_unit #(.PC_INIT(PC_INIT)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ihit          (ihit),
      .dhit          (dhit),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .PCSrc         (PCSrc),
      .Jump          (Jump),
      .halt_in       (halt_in),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .imemREN       (imemREN),
      .dmemREN       (dmemREN),
      .dmemWEN       (dmemWEN),
      .pc_en         (pc_en),
      .halt          (halt),
      .instr_count   (instr_count),
      .stall_cycles  (stall_cycles)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model.
   task automatic cyc(input bit rst, input bit ih, input bit dh, input bit mr,
                      input bit mw, input bit src, input bit jmp, input bit hlt,
                      input word_t bt, input word_t jt);
      word_t npc;
      bit    e_retire;
      RST = rst; ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw;
      PCSrc = src; Jump = jmp; halt_in = hlt; branch_target = bt; jump_target = jt;
      @(negedge CLK);
      npc = (jmp ? jt : (src ? bt : m_pc + 32'd4)) & 32'hFFFF_FFFC;
      if (m_halted)    e_retire = 1'b0;
      else if (m_busy) e_retire = dh;
      else             e_retire = ih & ~hlt & ~(mr | mw);
      if (rst) begin
         check("pc_en_in_reset", 32'(pc_en), 32'd0);
      end else begin
         check("pc", pc, m_pc);
         check("pc_plus4", pc_plus4, m_pc + 32'd4);
         check("imemREN", 32'(imemREN), 32'(!m_halted && !m_busy));
         check("dmemREN", 32'(dmemREN), 32'(m_busy && !m_wr));
         check("dmemWEN", 32'(dmemWEN), 32'(m_busy && m_wr));
         check("halt", 32'(halt), 32'(m_halted));
         check("pc_en", 32'(pc_en), 32'(e_retire));
`ifdef REQ_PERF_EN
         check("instr_count", instr_count, m_icnt);
         check("stall_cycles", stall_cycles, m_scnt);
`else
         check("instr_count", instr_count, 32'd0);
         check("stall_cycles", stall_cycles, 32'd0);
`endif
      end
      @(posedge CLK);
      if (rst) begin
         m_pc = PC_INIT; m_busy = 0; m_wr = 0; m_target = '0;
         m_halted = 0; m_icnt = '0; m_scnt = '0;
      end else if (m_halted) begin
         // frozen until reset
      end else if (m_busy) begin
         if (dh) begin m_pc = m_target; m_busy = 0; m_icnt++; end
         else m_scnt++;
      end else if (ih) begin
         if (hlt) m_halted = 1;
         else if (mr | mw) begin m_busy = 1; m_wr = mw; m_target = npc; end
         else begin m_pc = npc; m_icnt++; end
      end else begin
         m_scnt++;
      end
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic do_rst();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic ins(input bit mr, input bit mw, input bit src, input bit jmp,
                      input bit hlt, input word_t bt, input word_t jt);
      cyc(0, 1, 0, mr, mw, src, jmp, hlt, bt, jt);
   endtask

   task automatic dat(input bit dh);
      cyc(0, 0, dh, 0, 0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      RST = 1; ihit = 0; dhit = 0; MemRead = 0; MemWrite = 0;
      PCSrc = 0; Jump = 0; halt_in = 0; branch_target = '0; jump_target = '0;
      @(posedge CLK); #1;

      // Reset values, then a plain instruction retires in one cycle.
      do_rst();
      check("rst_pc", pc, 32'h100);
      check("rst_imemREN", 32'(imemREN), 32'd1);
      ins(0, 0, 0, 0, 0, '0, '0);
      check("seq_pc", pc, 32'h104);

      // Load with three stalled data cycles.
      ins(1, 0, 0, 0, 0, '0, '0);
      check("load_dmemREN", 32'(dmemREN), 32'd1);
      dat(0); dat(0); dat(0);
      dat(1);
      check("load_pc", pc, 32'h108);

      // Read+write resolves to write; jump beats branch.
      ins(1, 1, 1, 1, 0, 32'h300, 32'h200);
      check("rw_dmemWEN", 32'(dmemWEN), 32'd1);
      check("rw_dmemREN", 32'(dmemREN), 32'd0);
      dat(1);
      check("jump_pc", pc, 32'h200);

      // Halt at 0x40, sit for ten cycles under random fetch/data activity.
      ins(0, 0, 0, 1, 0, '0, 32'h40);
      ins(0, 0, 0, 0, 1, '0, '0);
      for (int i = 0; i < 10; i++)
         cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      check("halt_pc", pc, 32'h40);
      do_rst();
      check("halt_cleared", 32'(halt), 32'd0);

      // Reset in the middle of a store; a stray dhit in FETCH does nothing.
      ins(0, 0, 0, 1, 0, '0, 32'h80);
      ins(0, 1, 0, 0, 0, '0, '0);
      dat(0);
      do_rst();
      check("midrst_dmemWEN", 32'(dmemWEN), 32'd0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, '0, '0);
      check("stray_dhit_pc", pc, 32'h100);

      // Wrap at the top of the address space; unaligned branch target.
      ins(0, 0, 0, 1, 0, '0, 32'hFFFF_FFFC);
      ins(0, 0, 0, 0, 0, '0, '0);
      check("wrap_pc", pc, 32'h0);
      ins(0, 0, 1, 0, 0, 32'h103, '0);
      check("align_pc", pc, 32'h100);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         bit r_rst, r_hlt, r_mr, r_mw;
         r_rst = ($urandom_range(99) < 3);
         r_hlt = ($urandom_range(99) < 4);
         r_mr  = ($urandom_range(99) < 25);
         r_mw  = ($urandom_range(99) < 20);
         cyc(r_rst, $urandom_range(99) < 60, $urandom_range(99) < 50, r_mr, r_mw,
             1'($urandom), 1'($urandom), r_hlt, $urandom, $urandom);
      end
      nop(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_request_unit.md
# pc_request_unit

Sequencing stage directly downstream of the control unit in the single-cycle RISC-V datapath. It owns the program counter and arbitrates the single memory port between instruction fetch and data access. It consumes the decoded MemRead/MemWrite/PCSrc/Jump/halt signals for the current instruction and holds the PC until any data access completes. It drives the instruction and data request lines and latches halt.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous and active-high.
- ihit  in  1  instruction memory returned valid instruction this cycle.
- dhit  in  1  data memory completed the access this cycle.
- MemRead  in  1  current instruction is a load (from control unit).
- MemWrite  in  1  current instruction is a store (from control unit).
- PCSrc  in  1  conditional branch taken (from control unit).
- Jump  in  1  unconditional jump (from control unit).
- halt_in  in  1  current instruction is halt (from control unit).
- branch_target  in  32  branch destination address.
- jump_target  in  32  jump destination address.
- pc  out  32  current PC; also the instruction fetch address.
- pc_plus4  out  32  pc + 4, modulo 2^32 (link value).
- imemREN  out  1  instruction read request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- pc_en  out  1  strobe: PC loads next value at this edge (instruction retires).
- halt  out  1  sticky halted flag.
- instr_count  out  32  retired instructions. Only meaningful with REQ_PERF_EN.
- stall_cycles  out  32  cycles spent in FETCH without ihit or in DATA without dhit. Only meaningful with REQ_PERF_EN.

## Operation
- State machine reqstate_t has three states: FETCH, DATA, HALTED. imemREN/dmemREN/dmemWEN/halt decode from state and the latched request bits only (Moore).
- FETCH: imemREN=1, dmemREN=dmemWEN=0.
  - On ihit with halt_in: go to HALTED. PC is unchanged.
  - On ihit with MemRead|MemWrite: latch npc_q, rd_q=MemRead&~MemWrite, wr_q=MemWrite, then go to DATA. PC is unchanged.
  - On ihit with no memory op: pc_en=1, pc<=next_pc, stay in FETCH.
  - No ihit: hold.
- DATA: imemREN=0, dmemREN=rd_q, dmemWEN=wr_q.
  - On dhit: pc_en=1, pc<=npc_q, go to FETCH.
  - ihit is ignored in DATA.
- HALTED: all requests 0, halt=1, pc frozen, pc_en=0. Exits only on reset.
- next_pc = Jump ? jump_target : PCSrc ? branch_target : pc+4. Bits [1:0] are forced to 00.
- Priority: halt_in over memory op. Jump over PCSrc. MemWrite over MemRead: if both are set, a write is issued and dmemREN stays 0.
- dhit arriving in FETCH is ignored.
- Reset (any state, including mid-DATA): state=FETCH, pc=PC_INIT, rd_q=wr_q=0, npc_q=0, counters=0. An outstanding data request drops at the reset edge.
- Reset values of outputs: pc=PC_INIT, pc_plus4=PC_INIT+4, imemREN=1, dmemREN=0, dmemWEN=0, pc_en=0, halt=0, instr_count=0, stall_cycles=0.

## Timing
- Non-memory instruction: ihit in cycle N, pc_en=1 in N (combinational), new pc visible in N+1. One cycle minimum.
- Memory instruction: ihit in N, dmemREN/dmemWEN high from N+1. dhit in cycle M≥N+1 gives pc_en=1 in M, then FETCH and new pc in M+1. Two cycles minimum.
- Halt: ihit with halt_in in N, halt=1 from N+1. pc_en is never asserted for halt.
- Branch/jump inputs are sampled only in the ihit cycle. They may change freely afterwards.
- pc+4 wraps: 32'hFFFF_FFFC gives next 32'h0000_0000.

## Configuration
- REQ_PERF_EN defined:
  - instr_count increments on every pc_en.
  - stall_cycles increments each FETCH cycle without ihit and each DATA cycle without dhit.
  - Both counters are 32-bit wrapping, frozen in HALTED, and cleared by RST.
- REQ_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- cpu_types_pkg: add reqstate_t enum (FETCH, DATA, HALTED). Reuse word_t for 32-bit addresses.
- One sub-module, req_perf_counters, instantiated only under REQ_PERF_EN. It has inputs pc_en, stall, and halt, and outputs the two counters.
- The PC register and FSM stay in pc_request_unit.

## Test plan
- Reset with PC_INIT=32'h100: pc=32'h100, imemREN=1, others 0. Then ihit with no memory op: pc_en=1, pc=32'h104 the next cycle.
- Load: ihit+MemRead → dmemREN=1 next cycle. Hold dhit low 3 cycles: pc holds, stall_cycles=3. Then dhit → pc_en pulse, pc advances, imemREN=1.
- MemRead and MemWrite both set → dmemWEN=1, dmemREN=0. Also Jump=1 with PCSrc=1 and jump_target=32'h200 → pc=32'h200 after dhit.
- halt_in with ihit at pc=32'h40: halt=1 next cycle, all requests 0, pc stays 32'h40 for 10 cycles, no pc_en. Then RST → FETCH with halt=0.
- RST asserted mid-DATA with dmemWEN=1: next cycle dmemWEN=0, pc=PC_INIT, counters 0. A dhit arriving in FETCH causes no effect.
- pc=32'hFFFF_FFFC, ihit with no memory op: pc becomes 32'h0. branch_target=32'h103 with PCSrc → pc=32'h100.
